// File: rtl/gauss_filter.sv
// gauss_filter: 3x3 Gaussian smoothing of an 8-bit grayscale pixel stream.
// Two line buffers supply the previous two rows; the window is centred one pixel
// up-left of the incoming pixel. Pixels whose window is incomplete (first two rows
// or first two columns) pass through unfiltered. Three register stages deep.
module gauss_filter #(
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 720
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_img_vsync,
    input  logic       pre_img_hsync,
    input  logic       pre_img_valid,
    input  logic [7:0] pre_img_data,
    output logic       post_img_vsync,
    output logic       post_img_hsync,
    output logic       post_img_valid,
    output logic [7:0] post_img_data
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             validPrev_q;
    logic             validFall;

    // Line buffers: lineBuf1 holds row-1, lineBuf2 holds row-2, both indexed by column.
    logic [7:0] lineBuf1 [IMG_WIDTH];
    logic [7:0] lineBuf2 [IMG_WIDTH];
    logic [7:0] tapRow1, tapRow2;

    // Window columns: index 2 is the newest column, index 0 the oldest (col-2).
    logic [2:0][7:0] winTop_q, winMid_q, winBot_q;
    logic            full1_q, full2_q;
    logic [7:0]      pix1_q, pix2_q;
    logic            vs1_q, hs1_q, v1_q;
    logic            vs2_q, hs2_q, v2_q;
    logic [11:0]     sumComb, sum_q;
    logic [7:0]      roundedPix;

    assign tapRow1    = lineBuf1[col_q];
    assign tapRow2    = lineBuf2[col_q];
    assign validFall  = validPrev_q & ~pre_img_valid;
    assign roundedPix = 8'((sum_q + 12'd8) >> 4);

    // Column counts pixels within a line and clears after the line's last pixel;
    // row advances at each line end and is held at 0 during frame sync.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pre_img_valid) begin
            if (col_q != COL_LAST) col_d = col_q + COL_W'(1);
        end else if (validFall) begin
            col_d = '0;
        end
        if (pre_img_vsync) begin
            row_d = '0;
        end else if (validFall && (row_q != '1)) begin
            row_d = row_q + ROW_W'(1);
        end
    end

    // Position counters and the valid history used for line-end detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            validPrev_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            validPrev_q <= pre_img_valid;
        end
    end

    // Line buffer storage shifts the current column down one row on every valid pixel; no reset needed.
    always_ff @(posedge clk) begin
        if (pre_img_valid) begin
            lineBuf1[col_q] <= pre_img_data;
            lineBuf2[col_q] <= tapRow1;
        end
    end

    // Stage 1: shift the new column into the window and note whether the window is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winTop_q <= '0;
            winMid_q <= '0;
            winBot_q <= '0;
            full1_q  <= 1'b0;
            pix1_q   <= '0;
            vs1_q    <= 1'b0;
            hs1_q    <= 1'b0;
            v1_q     <= 1'b0;
        end else begin
            if (pre_img_valid) begin
                winTop_q <= {tapRow2, winTop_q[2:1]};
                winMid_q <= {tapRow1, winMid_q[2:1]};
                winBot_q <= {pre_img_data, winBot_q[2:1]};
            end
            full1_q <= (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            pix1_q  <= pre_img_data;
            vs1_q   <= pre_img_vsync;
            hs1_q   <= pre_img_hsync;
            v1_q    <= pre_img_valid;
        end
    end

    // Weighted 1-2-1 / 2-4-2 / 1-2-1 sum; worst case 16*255 = 4080 fits 12 bits.
    always_comb begin
        sumComb = {4'b0, winTop_q[0]} + {3'b0, winTop_q[1], 1'b0} + {4'b0, winTop_q[2]}
                + {3'b0, winMid_q[0], 1'b0} + {2'b0, winMid_q[1], 2'b0} + {3'b0, winMid_q[2], 1'b0}
                + {4'b0, winBot_q[0]} + {3'b0, winBot_q[1], 1'b0} + {4'b0, winBot_q[2]};
    end

    // Stage 2: register the kernel sum alongside the bypass pixel and syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            full2_q <= 1'b0;
            pix2_q  <= '0;
            vs2_q   <= 1'b0;
            hs2_q   <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            sum_q   <= sumComb;
            full2_q <= full1_q;
            pix2_q  <= pix1_q;
            vs2_q   <= vs1_q;
            hs2_q   <= hs1_q;
            v2_q    <= v1_q;
        end
    end

    // Stage 3: round the sum (or bypass the raw pixel) and force data to 0 outside valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_vsync <= 1'b0;
            post_img_hsync <= 1'b0;
            post_img_valid <= 1'b0;
            post_img_data  <= '0;
        end else begin
            post_img_vsync <= vs2_q;
            post_img_hsync <= hs2_q;
            post_img_valid <= v2_q;
            if (!v2_q) begin
                post_img_data <= '0;
            end else if (full2_q) begin
                post_img_data <= roundedPix;
            end else begin
                post_img_data <= pix2_q;
            end
        end
    end

endmodule

// File: tb/tb_gauss_filter.sv
// tb_gauss_filter: drives small frames through gauss_filter and compares every
// output cycle against an image-level model of the 3x3 Gaussian with pass-through borders.
module tb_gauss_filter;

    localparam int W = 16;
    localparam int H = 8;

    logic       clk;
    logic       rst_n;
    logic       preVsync, preHsync, preValid;
    logic [7:0] preData;
    logic       postVsync, postHsync, postValid;
    logic [7:0] postData;

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       v;
        logic [7:0] d;
    } expEntry_t;

    expEntry_t expQ[$];
    logic [7:0] img [H][W];
    int nAssert;
    int nFail;

    gauss_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pre_img_vsync  (preVsync),
        .pre_img_hsync  (preHsync),
        .pre_img_valid  (preValid),
        .pre_img_data   (preData),
        .post_img_vsync (postVsync),
        .post_img_hsync (postHsync),
        .post_img_valid (postValid),
        .post_img_data  (postData)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected output pixel at (r,c): smoothed value where a full 3x3 window exists above-left, else the input pixel.
    function automatic logic [7:0] modelPixel(int r, int c);
        int s;
        int wgt;
        if (r < 2 || c < 2) return img[r][c];
        s = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                wgt = ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1);
                s += wgt * int'(img[r - 2 + i][c - 2 + j]);
            end
        end
        return 8'((s + 8) / 16);
    endfunction

    task automatic checkOutput(input string tag, input expEntry_t e);
        nAssert++;
        assert ({postVsync, postHsync, postValid} === {e.vs, e.hs, e.v})
        else begin
            nFail++;
            $error("[TB] FAIL %s syncs: observed %b%b%b expected %b%b%b", tag,
                   postVsync, postHsync, postValid, e.vs, e.hs, e.v);
        end
        nAssert++;
        assert (postData === e.d)
        else begin
            nFail++;
            $error("[TB] FAIL %s data: observed %0d expected %0d", tag, postData, e.d);
        end
    endtask

    // One clock of stimulus; the output seen now belongs to the input driven two ticks earlier.
    task automatic applyStimulus(input string tag, input logic vs, input logic hs,
                                 input logic v, input logic [7:0] d, input logic [7:0] expD);
        expEntry_t e;
        preVsync = vs;
        preHsync = hs;
        preValid = v;
        preData  = d;
        @(posedge clk);
        #1;
        e.vs = vs; e.hs = hs; e.v = v; e.d = v ? expD : 8'd0;
        expQ.push_back(e);
        checkOutput(tag, expQ.pop_front());
    endtask

    task automatic primeQueue();
        expQ.delete();
        expQ.push_back('0);
        expQ.push_back('0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, expEntry_t'(0));
    endtask

    // Sends img[0..h-1][0..w-1]; abortRow >= 0 stops mid-way through that row.
    task automatic sendFrame(input string tag, input int h, input int w, input int abortRow);
        applyStimulus(tag, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        applyStimulus(tag, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int r = 0; r < h; r++) begin
            applyStimulus(tag, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
            for (int c = 0; c < w; c++) begin
                if (r == abortRow && c == w / 2) return;
                applyStimulus(tag, 1'b0, 1'b0, 1'b1, img[r][c], modelPixel(r, c));
            end
            repeat ($urandom_range(3, 1)) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        end
        repeat (3) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic fillRandom();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
    endtask

    initial begin
        nAssert  = 0;
        nFail    = 0;
        rst_n    = 1'b0;
        preVsync = 1'b0;
        preHsync = 1'b0;
        preValid = 1'b0;
        preData  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        primeQueue();

        $display("[TB] constant frame of 100");
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd100;
        sendFrame("const", H, W, -1);

        $display("[TB] single 255 impulse in zero field");
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd0;
        img[4][5] = 8'd255;
        sendFrame("impulse", H, W, -1);

        $display("[TB] horizontal ramp");
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'(c);
        sendFrame("ramp", H, W, -1);

        $display("[TB] back-to-back random frames");
        fillRandom();
        sendFrame("randA", H, W, -1);
        fillRandom();
        sendFrame("randB", H, W, -1);

        $display("[TB] reduced frame size");
        fillRandom();
        sendFrame("small", 5, 10, -1);

        $display("[TB] reset in the middle of a frame");
        fillRandom();
        sendFrame("abort", H, W, 3);
        rst_n = 1'b0;
        #1;
        checkAllZero("midReset");
        preVsync = 1'b0;
        preHsync = 1'b0;
        preValid = 1'b0;
        preData  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("midResetHeld");
        rst_n = 1'b1;
        primeQueue();
        fillRandom();
        sendFrame("postReset", H, W, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
